// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the instruction-fetch and
// the load/store data requesters. Round-robin on ties, bus command held
// across waitrequest stalls, one-cycle completion strobes, and a sticky
// watchdog flag for a bus stalled too long on one transaction.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   i_req, i_addr           fetch request (level) and byte address
//   i_ack, i_rdata          fetch completion strobe and read data
//   d_read, d_write         data request strobes (write wins if both high)
//   d_addr, d_wdata         data byte address and write data
//   d_byteenable            data lane enables
//   d_ack, d_rdata          data completion strobe and read data
//   waitrequest, readdata   bus stall and bus read data
//   read, write, address,
//   writedata, byteenable   registered bus command
//   timeout                 sticky watchdog flag
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteenable,
    output logic        d_ack,
    output logic [31:0] d_rdata,

    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        read,
    output logic        write,
    output logic [31:0] address,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,

    output logic        timeout
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS_I = 2'd1,
        ST_BUS_D = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [31:0]     address_q, address_d;
    logic [31:0]     writedata_q, writedata_d;
    logic [3:0]      byteenable_q, byteenable_d;
    logic [31:0]     i_rdata_q, i_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    logic d_req;
    logic grant_i;

    // Write takes precedence when both data strobes are high.
    assign d_req   = d_read | d_write;
    // Fetch wins when alone, or on a tie when data was granted last.
    assign grant_i = i_req & (~d_req | (last_grant_q == GRANT_D));

    // Next-state and bus-command logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        read_d       = read_q;
        write_d      = write_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        wd_d         = wd_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_i) begin
                    state_d      = ST_BUS_I;
                    last_grant_d = GRANT_I;
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                    address_d    = i_addr;
                    writedata_d  = 32'd0;
                    byteenable_d = 4'hF;
                    wd_d         = '0;
                end else if (d_req) begin
                    state_d      = ST_BUS_D;
                    last_grant_d = GRANT_D;
                    read_d       = d_read & ~d_write;
                    write_d      = d_write;
                    address_d    = d_addr;
                    writedata_d  = d_wdata;
                    byteenable_d = d_byteenable;
                    wd_d         = '0;
                end
            end
            ST_BUS_I, ST_BUS_D: begin
                if (!waitrequest) begin
                    state_d = ST_IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (state_q == ST_BUS_I) begin
                        i_rdata_d = readdata;
                    end else if (read_q) begin
                        d_rdata_d = readdata;
                    end
                end else if (wd_q != WD_MAX) begin
                    // Saturating stall counter.
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase

        timeout_d = timeout_q | (wd_d == WD_MAX);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_D;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= 32'd0;
            writedata_q  <= 32'd0;
            byteenable_q <= 4'd0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            read_q       <= read_d;
            write_q      <= write_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
        end
    end

    // Completion strobes are combinational; a reset cycle never completes.
    assign i_ack = ~reset & (state_q == ST_BUS_I) & ~waitrequest;
    assign d_ack = ~reset & (state_q == ST_BUS_D) & ~waitrequest;

    // Read data passes through in the completion cycle, held otherwise.
    assign i_rdata = i_ack ? readdata : i_rdata_q;
    assign d_rdata = (d_ack & read_q) ? readdata : d_rdata_q;

    assign read       = read_q;
    assign write      = write_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model compared
// against every output on every cycle, plus directed scenarios with
// hand-computed expectations.
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteenable;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_byteenable (d_byteenable),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .read         (read),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .timeout      (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner 0 = bus free, 1 = fetch, 2 = data.
    int          m_owner  = 0;
    bit          m_last_d = 1'b1;
    logic        m_rd     = 1'b0;
    logic        m_wr     = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    logic [3:0]  m_be     = '0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_hd     = '0;
    int          m_stalls = 0;
    bit          m_to     = 1'b0;

    always @(posedge clk) begin
        logic dreq;
        dreq = d_read | d_write;
        if (reset) begin
            m_owner = 0; m_last_d = 1'b1; m_rd = 1'b0; m_wr = 1'b0;
            m_addr = '0; m_wdata = '0; m_be = '0; m_hi = '0; m_hd = '0;
            m_stalls = 0; m_to = 1'b0;
        end else if (m_owner == 0) begin
            if (i_req && (!dreq || m_last_d)) begin
                m_owner = 1; m_last_d = 1'b0;
                m_rd = 1'b1; m_wr = 1'b0; m_addr = i_addr; m_wdata = '0; m_be = 4'hF;
                m_stalls = 0;
            end else if (dreq) begin
                m_owner = 2; m_last_d = 1'b1;
                m_wr = d_write; m_rd = !d_write;
                m_addr = d_addr; m_wdata = d_wdata; m_be = d_byteenable;
                m_stalls = 0;
            end
        end else if (!waitrequest) begin
            if (m_owner == 1) m_hi = readdata;
            else if (m_rd) m_hd = readdata;
            m_owner = 0; m_rd = 1'b0; m_wr = 1'b0;
        end else begin
            m_stalls++;
            if (m_stalls >= TO) m_to = 1'b1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic        e_iack, e_dack;
        logic [31:0] e_ird, e_drd;
        if (cmp_en) begin
            e_iack = !reset && m_owner == 1 && !waitrequest;
            e_dack = !reset && m_owner == 2 && !waitrequest;
            e_ird  = e_iack ? readdata : m_hi;
            e_drd  = (e_dack && m_rd) ? readdata : m_hd;
            chk("m_read",       32'(read),       32'(m_rd));
            chk("m_write",      32'(write),      32'(m_wr));
            chk("m_address",    address,         m_addr);
            chk("m_writedata",  writedata,       m_wdata);
            chk("m_byteenable", 32'(byteenable), 32'(m_be));
            chk("m_i_ack",      32'(i_ack),      32'(e_iack));
            chk("m_d_ack",      32'(d_ack),      32'(e_dack));
            chk("m_i_rdata",    i_rdata,         e_ird);
            chk("m_d_rdata",    d_rdata,         e_drd);
            chk("m_timeout",    32'(timeout),    32'(m_to));
            chk("ack_excl",     32'(i_ack & d_ack), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; i_req = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byteenable = '0;
        waitrequest = 1'b0; readdata = '0;
        step();
        cmp_en = 1;
        @(negedge clk);
        chk("rst_read",    32'(read),       32'd0);
        chk("rst_address", address,         32'd0);
        chk("rst_be",      32'(byteenable), 32'd0);
        chk("rst_i_rdata", i_rdata,         32'd0);
        chk("rst_timeout", 32'(timeout),    32'd0);

        // Single fetch, no stall
        step(); reset = 1'b0; i_req = 1'b1; i_addr = 32'hBFC0_0000; readdata = 32'h2402_0005;
        step();
        @(negedge clk);
        chk("f_read",    32'(read),       32'd1);
        chk("f_address", address,         32'hBFC0_0000);
        chk("f_be",      32'(byteenable), 32'hF);
        chk("f_ack",     32'(i_ack),      32'd1);
        chk("f_rdata",   i_rdata,         32'h2402_0005);
        step(); i_req = 1'b0; readdata = 32'h1111_1111;
        @(negedge clk);
        chk("f_read_drop", 32'(read),  32'd0);
        chk("f_ack_drop",  32'(i_ack), 32'd0);
        chk("f_rdata_hold", i_rdata,   32'h2402_0005);

        // Write stalled for 3 cycles
        step(); d_write = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEAD_BEEF;
        d_byteenable = 4'h3; waitrequest = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            waitrequest = (k == 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            chk("w_write", 32'(write),       32'd1);
            chk("w_read",  32'(read),        32'd0);
            chk("w_addr",  address,          32'h1000);
            chk("w_wdata", writedata,        32'hDEAD_BEEF);
            chk("w_be",    32'(byteenable),  32'h3);
            chk("w_ack",   32'(d_ack),       32'(k == 4));
        end
        step(); d_write = 1'b0;
        @(negedge clk);
        chk("w_write_drop", 32'(write), 32'd0);
        chk("w_addr_hold",  address,    32'h1000);
        chk("w_no_rdata",   d_rdata,    32'd0);

        // Tie: alternating grants starting with fetch
        step(); i_req = 1'b1; d_read = 1'b1; i_addr = 32'h100; d_addr = 32'h200;
        d_byteenable = 4'hF; waitrequest = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            readdata = 32'hA000_0000 + 32'(k);
            if (k == 8) begin
                i_req = 1'b0; d_read = 1'b0;
            end
            @(negedge clk);
            chk("t_iack", 32'(i_ack), 32'(k % 4 == 1));
            chk("t_dack", 32'(d_ack), 32'(k % 4 == 3));
            chk("t_read", 32'(read),  32'(k % 2 == 1));
            if (k % 4 == 1) chk("t_iaddr", address, 32'h100);
            if (k % 4 == 3) begin
                chk("t_daddr", address, 32'h200);
                chk("t_drdata", d_rdata, 32'hA000_0000 + 32'(k));
            end
        end

        // Read and write together: write only
        step(); d_read = 1'b1; d_write = 1'b1; d_addr = 32'h300; d_wdata = 32'h55AA_55AA;
        step();
        @(negedge clk);
        chk("c_write",  32'(write), 32'd1);
        chk("c_read",   32'(read),  32'd0);
        chk("c_addr",   address,    32'h300);
        chk("c_ack",    32'(d_ack), 32'd1);
        chk("c_rdata",  d_rdata,    32'hA000_0007);
        step(); d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
        chk("c_write_drop", 32'(write), 32'd0);

        // Watchdog
        step(); d_read = 1'b1; d_addr = 32'h400; waitrequest = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            @(negedge clk);
            chk("wd_timeout", 32'(timeout), 32'(k >= 5));
            chk("wd_read",    32'(read),    32'd1);
            chk("wd_ack",     32'(d_ack),   32'd0);
        end
        step(); waitrequest = 1'b0; readdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("wd_done_ack", 32'(d_ack),   32'd1);
        chk("wd_rdata",    d_rdata,      32'hCAFE_F00D);
        chk("wd_sticky",   32'(timeout), 32'd1);
        step(); d_read = 1'b0; readdata = 32'd0;
        @(negedge clk);
        chk("wd_sticky2",  32'(timeout), 32'd1);
        chk("wd_hold",     d_rdata,      32'hCAFE_F00D);
        step(); reset = 1'b1;
        @(negedge clk);
        chk("wd_pre_rst",  32'(timeout), 32'd1);
        step(); reset = 1'b0;
        @(negedge clk);
        chk("wd_cleared",  32'(timeout), 32'd0);

        // Reset during a stalled fetch
        step(); i_req = 1'b1; i_addr = 32'h500; waitrequest = 1'b1;
        step();
        @(negedge clk);
        chk("r_read",  32'(read),  32'd1);
        chk("r_addr",  address,    32'h500);
        step(); reset = 1'b1; waitrequest = 1'b0; readdata = 32'h7777_7777;
        @(negedge clk);
        chk("r_no_ack",   32'(i_ack), 32'd0);
        chk("r_no_rdata", i_rdata,    32'd0);
        step(); reset = 1'b0; i_req = 1'b0;
        @(negedge clk);
        chk("r_read0",  32'(read),       32'd0);
        chk("r_addr0",  address,         32'd0);
        chk("r_be0",    32'(byteenable), 32'd0);
        chk("r_ack0",   32'(i_ack),      32'd0);
        chk("r_irdata", i_rdata,         32'd0);
        chk("r_drdata", d_rdata,         32'd0);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter that shares the CPU's single memory bus between the instruction-fetch path and the load/store data path. It sits between `mips_cpu_bus` internals (fetch and memory-access logic) and the top-level bus pins (`read`, `write`, `address`, `writedata`, `byteenable`, `readdata`, `waitrequest`). It grants one requester at a time, holds bus outputs stable across `waitrequest` stalls, and returns read data and a completion strobe to the granted requester. It also flags a stuck bus via a watchdog counter.

## Interface
- `TIMEOUT_CYCLES`, default 1024: consecutive stall cycles on one transaction before `timeout` asserts.
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `i_req` input 1: fetch request, level; held until `i_ack`.
- `i_addr` input 32: fetch byte address.
- `i_ack` output 1: fetch completion strobe.
- `i_rdata` output 32: fetch read data.
- `d_read` input 1: data read request, level; held until `d_ack`.
- `d_write` input 1: data write request, level; held until `d_ack`.
- `d_addr` input 32: data byte address.
- `d_wdata` input 32: write data.
- `d_byteenable` input 4: data lane enables.
- `d_ack` output 1: data completion strobe.
- `d_rdata` output 32: data read data.
- `waitrequest` input 1: bus stall.
- `readdata` input 32: bus read data; valid in the cycle `read`=1 and `waitrequest`=0.
- `read`, `write` output 1 each: bus strobes.
- `address` output 32; `writedata` output 32; `byteenable` output 4: bus command, registered.
- `timeout` output 1: sticky watchdog flag.

## Operation
- FSM states:
  - IDLE: no bus strobe.
  - BUS_I: fetch transaction owns the bus.
  - BUS_D: data transaction owns the bus.
- IDLE→BUS_I / IDLE→BUS_D: on a sampled request. At the same edge, latch the command into the bus output registers:
  - Fetch: `read`=1, `address`=`i_addr`, `byteenable`=4'b1111, `writedata`=0.
  - Data: `read`/`write`, `address`, `writedata`, `byteenable` from the `d_*` inputs.
- Arbitration on simultaneous `i_req` and data request: round-robin. The grant goes to the port not granted last. `last_grant` resets to data, so fetch wins the first tie after reset.
- A data request is `d_read`|`d_write`. If both are high, it is treated as a write and `d_read` is ignored.
- Completion cycle: state BUS_x and `waitrequest`=0.
  - In that cycle, the granted port's ack=1 (combinational) and its rdata = `readdata` (pass-through). For writes, `d_rdata` keeps its held value.
  - The read value is stored in that port's held register (`i_rdata`/`d_rdata` show it outside completion cycles).
  - Next state is IDLE. At the edge, `read`/`write` drop to 0; `address`/`writedata`/`byteenable` hold.
- While `waitrequest`=1, all bus outputs stay constant and requester inputs are not resampled.
- Watchdog:
  - Counter clears on entry to BUS_x and increments each stalled cycle.
  - When it reaches `TIMEOUT_CYCLES`, `timeout` sets and stays set until reset. The transaction is not aborted.
  - The counter saturates and does not wrap.
- Requester contract: deassert or change the request at the edge following ack. A request still high in IDLE is a new transaction.

## Timing
- Reset values:
  - `read`=`write`=0; `address`=`writedata`=0; `byteenable`=0.
  - `i_ack`=`d_ack`=0; `i_rdata`=`d_rdata`=0; `timeout`=0.
  - State IDLE; `last_grant`=data; watchdog=0.
- Reset mid-transaction: the strobes are 0 from the next edge and no ack is issued. A coincident `waitrequest`=0 in the reset cycle is ignored.
- Latency with no stall: request seen in IDLE cycle N → bus strobe in N+1 → ack in N+1. IDLE at N+2.
- Throughput: at most one transaction per 2 cycles; every stall cycle adds 1.
- Acks are exactly one cycle wide and never both high.

## Test plan
- Single fetch: after reset, `i_req`=1, `i_addr`=0xBFC00000, `waitrequest`=0, `readdata`=0x24020005 → `read`=1 and `address`=0xBFC00000 with `byteenable`=0xF in cycle 1. `i_ack`=1 and `i_rdata`=0x24020005 in cycle 1. `read`=0 in cycle 2 and `i_rdata` holds.
- Stalled write: `d_write`=1, `d_addr`=0x1000, `d_wdata`=0xDEADBEEF, `d_byteenable`=0x3, `waitrequest` high for 3 cycles → bus command constant for 4 cycles and `d_ack`=1 only in the 4th. `write`=0 afterwards.
- Tie arbitration: `i_req` and `d_read` both held continuously, zero wait → grants alternate I, D, I, D starting with I. Acks land every 2nd cycle.
- Read+write conflict: `d_read`=`d_write`=1 → only `write`=1 on the bus.
- Watchdog: `TIMEOUT_CYCLES`=4 and `waitrequest` stuck high → `timeout`=1 after 4 stall cycles. Releasing `waitrequest` then completes with ack; `timeout` stays 1 until `reset`.
- Reset mid-read: `reset` pulsed during a stalled `read` → `read`=0 the next cycle, no ack, all outputs at reset values.
